// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel prescaler and freeze enable.
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CLK_DIV   = 1,
    parameter int   CW        = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic          pix_en_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          visible_o,
    output logic [CW-1:0] position_x_o,
    output logic [CW-1:0] position_y_o,
    output logic          line_start_o,
    output logic          frame_start_o
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_count_o
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [PW-1:0] P_END = PW'(CLK_DIV - 1);

    if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW)) || (CLK_DIV < 1))
    begin : g_bad_cfg
        $error("vga_timing_gen: CW too narrow for mode or CLK_DIV < 1");
    end

    logic [PW-1:0] r_pre;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_hs;
    logic          r_vs;
    logic          r_vis;
    logic          r_pix;
    logic          r_ls;
    logic          r_fs;

    logic          w_adv;
    logic          w_x_end;
    logic          w_y_end;
    logic [PW-1:0] w_pre_nxt;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_vis;
    logic          w_line;
    logic          w_frame;

    // Outputs are decoded from the next (x,y) so every flop describes one pixel.
    always_comb begin
        w_adv     = en_i && (r_pre == P_END);
        w_x_end   = (int'(r_x) == H_TOTAL - 1);
        w_y_end   = (int'(r_y) == V_TOTAL - 1);
        w_pre_nxt = r_pre;
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        if (en_i) begin
            w_pre_nxt = w_adv ? '0 : r_pre + P_ONE;
        end
        if (w_adv) begin
            w_x_nxt = w_x_end ? '0 : r_x + C_ONE;
            if (w_x_end) begin
                w_y_nxt = w_y_end ? '0 : r_y + C_ONE;
            end
        end
        w_hs_act = (int'(w_x_nxt) >= HS_BEG) && (int'(w_x_nxt) < HS_END);
        w_vs_act = (int'(w_y_nxt) >= VS_BEG) && (int'(w_y_nxt) < VS_END);
        w_vis    = (int'(w_x_nxt) < H_ACTIVE) && (int'(w_y_nxt) < V_ACTIVE);
        w_line   = w_adv && (w_x_nxt == '0);
        w_frame  = w_line && (w_y_nxt == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pre <= '0;
            r_x   <= CW'(H_TOTAL - 1);
            r_y   <= CW'(V_TOTAL - 1);
            r_hs  <= ~HSYNC_POL;
            r_vs  <= ~VSYNC_POL;
            r_vis <= 1'b0;
            r_pix <= 1'b0;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_pre <= w_pre_nxt;
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_hs  <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            r_vs  <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            r_vis <= w_vis;
            r_pix <= w_adv;
            r_ls  <= w_line;
            r_fs  <= w_frame;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_fcnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fcnt <= '0;
        end else if (w_frame) begin
            r_fcnt <= r_fcnt + 16'd1;
        end
    end

    assign frame_count_o = r_fcnt;
`endif

    assign pix_en_o      = r_pix;
    assign hsync_o       = r_hs;
    assign vsync_o       = r_vs;
    assign visible_o     = r_vis;
    assign position_x_o  = r_x;
    assign position_y_o  = r_y;
    assign line_start_o  = r_ls;
    assign frame_start_o = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a standard-width mode with short frames
// and a tiny prescaled mode, checked against hand-computed raster positions.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, en;

    logic       b_pix, b_hs, b_vs, b_vis, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic       a_pix, a_hs, a_vs, a_vis, a_ls, a_fs;
    logic [3:0] a_x, a_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] b_fc, a_fc;
`endif

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_b), .en_i(en),
        .pix_en_o(b_pix), .hsync_o(b_hs), .vsync_o(b_vs),
        .visible_o(b_vis), .position_x_o(b_x), .position_y_o(b_y),
        .line_start_o(b_ls), .frame_start_o(b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_count_o(b_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(3), .CW(4)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_a), .en_i(en),
        .pix_en_o(a_pix), .hsync_o(a_hs), .vsync_o(a_vs),
        .visible_o(a_vis), .position_x_o(a_x), .position_y_o(a_y),
        .line_start_o(a_ls), .frame_start_o(a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_count_o(a_fc)
`endif
    );

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b_bad, a_bad, hold_bad, strobes;
        int b_fs_n, b_ls_n, b_ls_last, b_ls_bad, b_fs_last, b_fs_bad;
        int a_fs_n, a_ls_n, a_ls_last, a_ls_bad, a_fs_last, a_fs_bad;
        int b_vis_n, a_vis_n, steps;
        bit found;

        n_checks = 0; n_errors = 0;
        b_bad = 0; a_bad = 0;
        b_fs_n = 0; b_ls_n = 0; b_ls_bad = 0; b_fs_bad = 0;
        a_fs_n = 0; a_ls_n = 0; a_ls_bad = 0; a_fs_bad = 0;
        b_ls_last = -1; b_fs_last = -1; a_ls_last = -1; a_fs_last = -1;
        b_vis_n = 0; a_vis_n = 0;

        rst_a = 1'b0; rst_b = 1'b0; en = 1'b1;
        repeat (3) tick;
        check("rst_b_x", int'(b_x), 799);
        check("rst_b_y", int'(b_y), 9);
        check("rst_b_hs", int'(b_hs), 1);
        check("rst_b_vs", int'(b_vs), 1);
        check("rst_b_vis", int'(b_vis), 0);
        check("rst_b_strobes", int'({b_pix, b_ls, b_fs}), 0);
        check("rst_a_x", int'(a_x), 7);
        check("rst_a_y", int'(a_y), 5);

        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        for (int c = 1; c <= 16100; c++) begin
            int x, y, k, p, ax, ay;
            bit ehs, evs, evis, eapix, eals, eafs;
            tick;
            x = (c - 1) % 800;
            y = ((c - 1) / 800) % 10;
            ehs  = !(x >= 656 && x < 752);
            evs  = !(y >= 6 && y < 8);
            evis = (x < 640) && (y < 4);
            if (int'(b_x) != x || int'(b_y) != y || b_hs != ehs ||
                b_vs != evs || b_vis != evis || b_pix != 1'b1 ||
                b_ls != (x == 0) || b_fs != (x == 0 && y == 0))
                b_bad++;

            k = c / 3;
            eapix = (c % 3 == 0);
            if (k == 0) begin
                ax = 7; ay = 5;
            end else begin
                p = (k - 1) % 48;
                ax = p % 8; ay = p / 8;
            end
            eals = eapix && (ax == 0);
            eafs = eals && (ay == 0);
            if (int'(a_x) != ax || int'(a_y) != ay ||
                a_hs != !(ax >= 5 && ax < 7) || a_vs != !(ay == 4) ||
                a_vis != (k > 0 && ax < 4 && ay < 3) ||
                a_pix != eapix || a_ls != eals || a_fs != eafs)
                a_bad++;

            if (b_ls) begin
                if (b_ls_last >= 0 && c - b_ls_last != 800) b_ls_bad++;
                b_ls_last = c; b_ls_n++;
            end
            if (b_fs) begin
                if (b_fs_last >= 0 && c - b_fs_last != 8000) b_fs_bad++;
                b_fs_last = c; b_fs_n++;
            end
            if (a_ls) begin
                if (a_ls_last >= 0 && c - a_ls_last != 24) a_ls_bad++;
                a_ls_last = c; a_ls_n++;
            end
            if (a_fs) begin
                if (a_fs_last >= 0 && c - a_fs_last != 144) a_fs_bad++;
                a_fs_last = c; a_fs_n++;
            end
            if (c <= 8000 && b_vis) b_vis_n++;
            if (c >= 3 && c <= 146 && a_vis) a_vis_n++;

            if (c == 1)    check("b_first_fs", int'(b_fs), 1);
            if (c == 2)    check("a_pix_edge2", int'(a_pix), 0);
            if (c == 3)    check("a_first_fs", int'(a_fs), 1);
            if (c == 4)    check("a_hold_x", int'(a_x), 0);
            if (c == 641)  check("b_vis_x640", int'(b_vis), 0);
            if (c == 656)  check("b_hs_x655", int'(b_hs), 1);
            if (c == 657)  check("b_hs_x656", int'(b_hs), 0);
            if (c == 752)  check("b_hs_x751", int'(b_hs), 0);
            if (c == 753)  check("b_hs_x752", int'(b_hs), 1);
            if (c == 3201) check("b_vis_y4", int'(b_vis), 0);
            if (c == 4800) check("b_vs_y5", int'(b_vs), 1);
            if (c == 4801) check("b_vs_y6", int'(b_vs), 0);
            if (c == 6401) check("b_vs_y8", int'(b_vs), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (c == 3)    check("a_fcnt_1", int'(a_fc), 1);
            if (c == 147)  check("a_fcnt_2", int'(a_fc), 2);
            if (c == 1)    check("b_fcnt_1", int'(b_fc), 1);
`endif
        end

        check("b_scan_bad", b_bad, 0);
        check("a_scan_bad", a_bad, 0);
        check("b_frames", b_fs_n, 3);
        check("b_frame_gap_bad", b_fs_bad, 0);
        check("b_lines", b_ls_n, 21);
        check("b_line_gap_bad", b_ls_bad, 0);
        check("a_frames", a_fs_n, 112);
        check("a_frame_gap_bad", a_fs_bad, 0);
        check("a_lines", a_ls_n, 671);
        check("a_line_gap_bad", a_ls_bad, 0);
        check("b_vis_cycles", b_vis_n, 2560);
        check("a_vis_cycles", a_vis_n, 36);

        @(negedge clk); rst_b = 1'b0;
        @(negedge clk); rst_b = 1'b1;
        repeat (1101) tick;
        check("frz_pre_x", int'(b_x), 300);
        check("frz_pre_y", int'(b_y), 1);
        en = 1'b0;
        hold_bad = 0; strobes = 0;
        repeat (17) begin
            tick;
            if (int'(b_x) != 300 || int'(b_y) != 1 || b_hs != 1'b1 ||
                b_vs != 1'b1 || b_vis != 1'b1)
                hold_bad++;
            strobes += int'(b_pix) + int'(b_ls) + int'(b_fs);
        end
        check("frz_hold_bad", hold_bad, 0);
        check("frz_strobes", strobes, 0);
        en = 1'b1;
        tick;
        check("frz_resume_x", int'(b_x), 301);
        check("frz_resume_y", int'(b_y), 1);
        check("frz_resume_pix", int'(b_pix), 1);

        found = 1'b0;
        steps = 0;
        while (!found && steps < 10000) begin
            tick;
            steps++;
            if (int'(b_x) == 700 && int'(b_y) == 7) found = 1'b1;
        end
        check("rst_mid_reached", int'(found), 1);
        check("rst_mid_hs_pre", int'(b_hs), 0);
        check("rst_mid_vs_pre", int'(b_vs), 0);
        rst_b = 1'b0;
        #1;
        check("rst_mid_x", int'(b_x), 799);
        check("rst_mid_y", int'(b_y), 9);
        check("rst_mid_hs", int'(b_hs), 1);
        check("rst_mid_vs", int'(b_vs), 1);
        check("rst_mid_vis", int'(b_vis), 0);
        check("rst_mid_strobes", int'({b_pix, b_ls, b_fs}), 0);
        @(negedge clk); rst_b = 1'b1;
        tick;
        check("rel_x", int'(b_x), 0);
        check("rel_y", int'(b_y), 0);
        check("rel_fs", int'(b_fs), 1);
        check("rel_ls", int'(b_ls), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
